// File: rtl/reg_pkg.sv
// Shared types for the register-read issue path.
//   reg_t          architectural register index
//   reg_busy_t     one busy bit per architectural register
//   reg_fur_sig_t  decoded instruction payload carried from decode to the ALU
//   ri_state_t     issue-controller entry state
// Helper: reg_writes_busy() tells whether an instruction claims a scoreboard bit.
package reg_pkg;

    localparam int NUM_REGS_DFLT = 32;
    localparam int REG_IDX_W     = $clog2(NUM_REGS_DFLT);

    typedef logic [REG_IDX_W-1:0]     reg_t;
    typedef logic [NUM_REGS_DFLT-1:0] reg_busy_t;

    typedef enum logic {
        ALU_S1_RS1 = 1'b0,
        ALU_S1_PC  = 1'b1
    } alu_s1_font_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } alu_opcode_t;

    typedef struct packed {
        alu_s1_font_t alu_s1_font;
        alu_opcode_t  alu_opcode;
        logic         wb_wr;
        reg_t         reg_dst;
        logic [31:0]  imm;
    } reg_fur_sig_t;

    typedef enum logic {
        RI_EMPTY = 1'b0,
        RI_HOLD  = 1'b1
    } ri_state_t;

    // r0 is hard-wired zero, so writes to it never occupy the scoreboard.
    function automatic logic reg_writes_busy(input reg_fur_sig_t s);
        return s.wb_wr && (s.reg_dst != '0);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard for in-flight writes.
//   set_en/set_reg   mark a register busy (issue of a writing instruction)
//   clr_en/clr_reg   clear a register (writeback retires)
//   rd_rs1/rd_rs2/rd_dst -> busy_rs1/busy_rs2/busy_dst   hazard lookups
//   busy             registered busy vector snapshot
// Same-cycle set and clear of one register: set wins. Register 0 is never busy.
// Build option REG_ISSUE_BYPASS_EN: a clear in the current cycle is already
// visible to the lookups, so a waiting dependent can issue in the writeback cycle.
module reg_scoreboard
    import reg_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DFLT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  reg_t                set_reg,
    input  logic                clr_en,
    input  reg_t                clr_reg,
    input  reg_t                rd_rs1,
    input  reg_t                rd_rs2,
    input  reg_t                rd_dst,
    output logic                busy_rs1,
    output logic                busy_rs2,
    output logic                busy_dst,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] busy_view;

    // Masks start at index 1 so r0 can never be set or need clearing.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (set_en && (set_reg == reg_t'(i))) set_mask[i] = 1'b1;
            if (clr_en && (clr_reg == reg_t'(i))) clr_mask[i] = 1'b1;
        end
        // Clear first, then set, so a same-cycle set survives.
        busy_d = (busy_q & ~clr_mask) | set_mask;
    end

    always_comb begin
`ifdef REG_ISSUE_BYPASS_EN
        busy_view = busy_q & ~clr_mask;
`else
        busy_view = busy_q;
`endif
        busy_rs1 = busy_view[rd_rs1];
        busy_rs2 = busy_view[rd_rs2];
        busy_dst = busy_view[rd_dst];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy = busy_q;

endmodule

// File: rtl/reg_issue_ctrl.sv
// Register-read issue controller between decode and the ALU.
// Holds one decoded instruction, stalls it while a source or its destination
// has an in-flight write, and hands it to the ALU over valid/ready.
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready, in_sig,
//   in_rs1(_used), in_rs2(_used)     decode side
//   out_valid/out_ready, out_sig,
//   out_rs1, out_rs2                 ALU side (held payload)
//   wb_valid, wb_reg                 writeback retirement
//   flush                            drop the held instruction
//   busy_o                           scoreboard snapshot
//   stall_cnt                        saturating count of stalled held cycles
// Build option REG_ISSUE_BYPASS_EN: writeback clears unblock a dependent in the
// same cycle instead of the next one.
module reg_issue_ctrl
    import reg_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DFLT,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  reg_fur_sig_t        in_sig,
    input  reg_t                in_rs1,
    input  logic                in_rs1_used,
    input  reg_t                in_rs2,
    input  logic                in_rs2_used,
    output logic                out_valid,
    input  logic                out_ready,
    output reg_fur_sig_t        out_sig,
    output reg_t                out_rs1,
    output reg_t                out_rs2,
    input  logic                wb_valid,
    input  reg_t                wb_reg,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy_o,
    output logic [CNT_W-1:0]    stall_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    ri_state_t          state_q;
    ri_state_t          state_d;
    reg_fur_sig_t       sig_p1;
    reg_t               rs1_p1;
    reg_t               rs2_p1;
    logic               rs1_used_p1;
    logic               rs2_used_p1;
    logic               vld_p1;
    logic               busy_rs1;
    logic               busy_rs2;
    logic               busy_dst;
    logic               hazard;
    logic               issue;
    logic               accept;
    logic [CNT_W-1:0]   stall_q;

    assign vld_p1 = (state_q == RI_HOLD);

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issue && reg_writes_busy(sig_p1)),
        .set_reg  (sig_p1.reg_dst),
        .clr_en   (wb_valid),
        .clr_reg  (wb_reg),
        .rd_rs1   (rs1_p1),
        .rd_rs2   (rs2_p1),
        .rd_dst   (sig_p1.reg_dst),
        .busy_rs1 (busy_rs1),
        .busy_rs2 (busy_rs2),
        .busy_dst (busy_dst),
        .busy     (busy_o)
    );

    // RAW on either used source, WAW on the destination; one write in flight
    // per register is enough, so no tags are needed.
    assign hazard = (rs1_used_p1 && busy_rs1) ||
                    (rs2_used_p1 && busy_rs2) ||
                    (sig_p1.wb_wr && busy_dst);

    // Handshake and next-state. flush dominates both handshakes.
    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        in_ready  = 1'b0;
        issue     = 1'b0;
        accept    = 1'b0;

        out_valid = vld_p1 && !hazard && !flush;
        issue     = out_valid && out_ready;
        in_ready  = (!vld_p1 || issue) && !flush;
        accept    = in_valid && in_ready;

        unique case (state_q)
            RI_EMPTY: if (accept) state_d = RI_HOLD;
            RI_HOLD:  if (issue && !accept) state_d = RI_EMPTY;
            default:  state_d = RI_EMPTY;
        endcase
        if (flush) state_d = RI_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RI_EMPTY;
        else        state_q <= state_d;
    end

    // Stage p1: held payload, loaded only on accept; flush leaves it as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_p1      <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rs1_used_p1 <= 1'b0;
            rs2_used_p1 <= 1'b0;
        end else if (accept) begin
            sig_p1      <= in_sig;
            rs1_p1      <= in_rs1;
            rs2_p1      <= in_rs2;
            rs1_used_p1 <= in_rs1_used;
            rs2_used_p1 <= in_rs2_used;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        stall_q <= '0;
        else if (vld_p1 && !out_valid && !flush) stall_q <= sat_inc(stall_q);
    end

    assign out_sig   = sig_p1;
    assign out_rs1   = rs1_p1;
    assign out_rs2   = rs2_p1;
    assign stall_cnt = stall_q;

endmodule
